// File: rtl/clk_mon_scheduler.sv
// Sweeps up to eight clocks through one shared external counter: select, settle, clear,
// gate, drain, then capture the count and range-check it. Results can be read back per channel.
module clk_mon_scheduler #(
   parameter int GATE_CYCLES   = 1000000,
   parameter int SETTLE_CYCLES = 64,
   parameter int CLEAR_CYCLES  = 16,
   parameter int DRAIN_CYCLES  = 16
) (
   input  logic        clk100,
   input  logic        reset_in,
   input  logic        start,
   input  logic        continuous,
   input  logic        abort,
   input  logic [7:0]  enable_mask,
   input  logic [23:0] min_count,
   input  logic [23:0] max_count,
   input  logic [23:0] cnt_value,
   output logic [2:0]  mux_sel,
   output logic        cnt_clear,
   output logic        cnt_enable,
   input  logic [2:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [7:0]  alarm,
   output logic        busy,
   output logic        sweep_done
);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CLEAR, S_GATE, S_DRAIN, S_CAPTURE, S_NEXT} state_t;

   localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
   localparam logic [23:0] CLEAR_LAST  = 24'(CLEAR_CYCLES - 1);
   localparam logic [23:0] GATE_LAST   = 24'(GATE_CYCLES - 1);
   localparam logic [23:0] DRAIN_LAST  = 24'(DRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic [7:0]  mask_q, mask_d;
   logic [2:0]  sel_q, sel_d;
   logic        done_q, done_d;
   logic        clr_q, clr_d;
   logic        en_q, en_d;
   logic [7:0]  alarm_q;
   logic [31:0] rd_q;
   logic [31:0] result_q [8];
   logic [3:0]  nxt_bit, first_bit;

   // Returns {found, index} of the lowest set bit of m at or above lo.
   function automatic logic [3:0] find_bit(input logic [7:0] m, input logic [3:0] lo);
      logic [3:0] r;
      r = 4'b0;
      for (int i = 7; i >= 0; i--)
         if (m[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
      return r;
   endfunction

   always_ff @(posedge clk100 or posedge reset_in) begin
      if (reset_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         sel_q   <= '0;
         done_q  <= 1'b0;
         clr_q   <= 1'b1;
         en_q    <= 1'b0;
         alarm_q <= '0;
         rd_q    <= 32'hFFFF_FFFF;
         for (int i = 0; i < 8; i++) result_q[i] <= 32'hFFFF_FFFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         en_q    <= en_d;
         rd_q    <= result_q[rd_addr];
         if (state_q == S_CAPTURE && !abort) begin
            result_q[sel_q] <= {8'h00, cnt_value};
            alarm_q[sel_q]  <= (cnt_value < min_count) | (cnt_value > max_count) |
                               (cnt_value == 24'hFF_FFFF);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 24'd1;
      mask_d    = mask_q;
      sel_d     = sel_q;
      done_d    = 1'b0;
      nxt_bit   = find_bit(mask_q, {1'b0, sel_q} + 4'd1);
      first_bit = find_bit(enable_mask, 4'd0);
      case (state_q)
         S_IDLE: if (start) begin
            mask_d = enable_mask;
            if (first_bit[3]) begin
               state_d = S_SETTLE;
               sel_d   = first_bit[2:0];
            end else done_d = 1'b1;
         end
         S_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = S_CLEAR;
         S_CLEAR:   if (cnt_q == CLEAR_LAST)  state_d = S_GATE;
         S_GATE:    if (cnt_q == GATE_LAST)   state_d = S_DRAIN;
         S_DRAIN:   if (cnt_q == DRAIN_LAST)  state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_NEXT;
         S_NEXT: if (nxt_bit[3]) begin
            state_d = S_SETTLE;
            sel_d   = nxt_bit[2:0];
         end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (continuous) begin
               mask_d = enable_mask;
               if (first_bit[3]) begin
                  state_d = S_SETTLE;
                  sel_d   = first_bit[2:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      // Abort overrides everything, including a simultaneous start or end of sweep.
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         mask_d  = mask_q;
         sel_d   = sel_q;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      clr_d = (state_d == S_CLEAR);
      en_d  = (state_d == S_GATE);
      busy  = (state_q != S_IDLE);
   end

   assign mux_sel    = sel_q;
   assign cnt_clear  = clr_q;
   assign cnt_enable = en_q;
   assign rd_data    = rd_q;
   assign alarm      = alarm_q;
   assign sweep_done = done_q;

endmodule

// File: doc/clk_mon_scheduler.md
CLK_MON_SCHEDULER -- requirements
Module: clk_mon_scheduler

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000000, clk100 cycles cnt_enable is held high per measurement.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64, wait after changing mux_sel before clearing.
REQ-003 SHALL have parameter CLEAR_CYCLES, default 16, cycles cnt_clear is held high.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 16, wait after gate closes before sampling cnt_value.
REQ-005 SHALL have ports, clock and reset first. Reset is reset_in, asynchronous, active-high; clock is clk100.
- clk100  in  1  reference clock, 100 MHz; all logic in this domain
- reset_in  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a sweep
- continuous  in  1  1 = restart the sweep automatically after the last channel
- abort  in  1  one-cycle request to stop the sweep at once
- enable_mask  in  8  channel n is measured when bit n = 1
- min_count  in  24  lower alarm limit, inclusive
- max_count  in  24  upper alarm limit, inclusive
- cnt_value  in  24  external shared counter output, quasi-static after drain
- mux_sel  out  3  select for the external clock mux feeding the shared counter
- cnt_clear  out  1  clear to the shared counter
- cnt_enable  out  1  gate to the shared counter; the counter side synchronizes it
- rd_addr  in  3  result readback channel
- rd_data  out  32  registered result for rd_addr, one-cycle latency
- alarm  out  8  per-channel out-of-range flags
- busy  out  1  high whenever state is not IDLE
- sweep_done  out  1  one-cycle pulse at the end of each sweep

Function
REQ-006 States SHALL be IDLE, SETTLE, CLEAR, GATE, DRAIN, CAPTURE, NEXT.
REQ-007 IDLE -> SETTLE when start=1. On that edge: latch enable_mask into sweep_mask; set mux_sel to the lowest set bit of sweep_mask.
REQ-008 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CLEAR.
REQ-009 CLEAR SHALL hold cnt_clear=1 for exactly CLEAR_CYCLES cycles, then go to GATE. cnt_clear is 0 in every other state.
REQ-010 GATE SHALL hold cnt_enable=1 for exactly GATE_CYCLES cycles, then go to DRAIN. cnt_enable is 0 in every other state.
REQ-011 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then go to CAPTURE.
REQ-012 CAPTURE SHALL last 1 cycle:
- result[mux_sel] <= {8'h00, cnt_value}
- alarm[mux_sel] <= (cnt_value < min_count) | (cnt_value > max_count) | (cnt_value == 24'hFFFFFF)
REQ-013 NEXT SHALL set mux_sel to the next higher set bit of sweep_mask and go to SETTLE.
REQ-014 When no higher set bit exists, NEXT SHALL pulse sweep_done for 1 cycle. Then:
- continuous=1: re-latch enable_mask and go to SETTLE with the lowest set bit.
- continuous=0: go to IDLE.
REQ-015 start with enable_mask==0 SHALL pulse sweep_done the next cycle and remain in IDLE. Continuous restart with an all-zero mask SHALL do the same.
REQ-016 start while busy SHALL be ignored. Changes to enable_mask mid-sweep SHALL take effect only at the next latch.
REQ-017 abort SHALL, on the next edge, from any state:
- go to IDLE
- deassert cnt_enable and cnt_clear
- not pulse sweep_done
- leave results and alarms unchanged
REQ-018 abort and start asserted in the same cycle: abort SHALL win.
REQ-019 mux_sel SHALL change only on entry to SETTLE.
REQ-020 rd_data SHALL equal result[rd_addr] registered, one clk100 cycle after rd_addr.
REQ-021 A 24-bit counter SHALL implement each timed state; the design SHALL support parameter values 1..2^24-1.

Reset
REQ-022 reset_in=1 SHALL asynchronously force:
- state IDLE, mux_sel=0
- cnt_clear=1, cnt_enable=0
- busy=0, sweep_done=0
- alarm=8'h00
- all results and rd_data = 32'hFFFFFFFF ("never measured")
REQ-023 reset_in asserted mid-sweep SHALL discard the partial measurement. Outputs other than cnt_clear SHALL reach their reset values within 1 cycle of deassertion.

Verification (SETTLE=4, CLEAR=2, GATE=100, DRAIN=3 for all scenarios)
REQ-024 Scenario 1:
- Stimulus: mask=8'h05, continuous=0, start; model the counter as 50 MHz test clock.
- Required: result[0]=result[2]=32'h00000032; result[1]=32'hFFFFFFFF; exactly one sweep_done; busy drops with it.
REQ-025 Scenario 2:
- Stimulus: channel 3 test clock stopped, min_count=10, mask=8'h08.
- Required: result[3]=0, alarm[3]=1; alarm for any in-range channel = 0.
REQ-026 Scenario 3:
- Stimulus: abort during GATE of channel 1.
- Required: IDLE next cycle; cnt_enable=0; result[1] unchanged; no sweep_done.
REQ-027 Scenario 4:
- Stimulus: continuous=1, mask=8'h81.
- Required: mux_sel sequence 0,7,0,7; sweep_done every 2 channels; cycles per channel = 4+2+100+3+1+1.
REQ-028 Scenario 5:
- Stimulus: start with mask=0.
- Required: sweep_done one cycle later; busy never 1.
REQ-029 Scenario 6:
- Stimulus: reset_in pulsed during DRAIN.
- Required: all outputs at REQ-022 values; rd_data=32'hFFFFFFFF for every rd_addr.
